// File: rtl/crc_frame_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | crc_frame_pkg : FSM state type and CRC-8 step shared by the frame   |
// | transmitter.                              Revision: 1.0             |
// +--------------------------------------------------------------------+
package crc_frame_pkg;

  typedef enum logic [2:0] {
    FILL     = 3'd0,
    SEND_CNT = 3'd1,
    SEND_DAT = 3'd2,
    SEND_CRC = 3'd3,
    WAIT_RES = 3'd4,
    REPORT   = 3'd5
  } state_t;

  localparam logic [7:0] CRC_POLY_DEF = 8'h07;

  // One byte of MSB-first CRC-8: data folds in first, then eight shift/XOR steps.
  function automatic logic [7:0] crc8_next(
    input logic [7:0] crc,
    input logic [7:0] data,
    input logic [7:0] poly
  );
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc8_acc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | crc8_acc : registered CRC-8 accumulator with clear and enable.     |
// |                                           Revision: 1.0             |
// +--------------------------------------------------------------------+
module crc8_acc
  import crc_frame_pkg::*;
#(
  parameter logic [7:0] CRC_POLY = CRC_POLY_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc8_next(crc, data, CRC_POLY);
    end
  end

endmodule
`default_nettype wire

// File: rtl/crc_frame_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | crc_frame_tx : buffers one frame, sends length, bytes and CRC-8,    |
// | then awaits the checker token. CRC_FTX_ERR_INJECT_EN adds err_inj.  |
// |                                           Revision: 1.0             |
// +--------------------------------------------------------------------+
module crc_frame_tx
  import crc_frame_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 64,
  parameter logic [7:0] CRC_POLY    = CRC_POLY_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_empty,
`ifdef CRC_FTX_ERR_INJECT_EN
  input  logic       err_inj,
`endif
  output logic       cnt_valid,
  input  logic       cnt_ready,
  output logic [7:0] cnt_data,
  output logic       dat_valid,
  input  logic       dat_ready,
  output logic [7:0] dat_data,
  input  logic       res_valid,
  output logic       res_ready,
  input  logic       res_data,
  output logic       done,
  output logic       pass,
  output logic       ovf
);

  localparam int              AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  state_t          state;
  logic [7:0]      len;
  logic [7:0]      rd;
  logic [TW-1:0]   timer;
  logic            ovf_flag;
  logic [7:0]      mem [MAX_LEN];
  logic [7:0]      crc;
  logic [7:0]      crc_tx;
  logic            take;
  logic            take_byte;
  logic            crc_clr;
  logic [7:0]      len_inc;
  logic [AW-1:0]   rd_nidx;

  assign take      = (state == FILL) && in_valid && in_ready;
  assign take_byte = take && !in_empty;
  assign len_inc   = len + 8'd1;
  assign rd_nidx   = rd[AW-1:0] + AW'(1);
  assign crc_clr   = (state == REPORT);
  assign cnt_data  = len;

  crc8_acc #(
    .CRC_POLY (CRC_POLY)
  ) u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (take_byte),
    .data  (in_data),
    .crc   (crc)
  );

`ifdef CRC_FTX_ERR_INJECT_EN
  logic inj;

  // Latched with the closing beat so the corruption applies to this frame only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj <= 1'b0;
    end else if (take && in_last) begin
      inj <= err_inj;
    end else if (state == REPORT) begin
      inj <= 1'b0;
    end
  end

  assign crc_tx = crc ^ {7'd0, inj};
`else
  assign crc_tx = crc;
`endif

  // Frame buffer carries no reset; len alone marks which entries are live.
  always_ff @(posedge clk) begin
    if (take_byte) begin
      mem[len[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      len       <= 8'd0;
      rd        <= 8'd0;
      timer     <= '0;
      ovf_flag  <= 1'b0;
      in_ready  <= 1'b0;
      cnt_valid <= 1'b0;
      dat_valid <= 1'b0;
      dat_data  <= 8'h00;
      res_ready <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (take_byte) begin
            len <= len_inc;
            // A full buffer closes the frame even without in_last.
            if (in_last || (len_inc == MAX_LEN_B)) begin
              ovf_flag  <= !in_last;
              in_ready  <= 1'b0;
              cnt_valid <= 1'b1;
              state     <= SEND_CNT;
            end
          end else if (take && in_last) begin
            in_ready  <= 1'b0;
            cnt_valid <= 1'b1;
            state     <= SEND_CNT;
          end
        end

        SEND_CNT: begin
          if (cnt_ready) begin
            cnt_valid <= 1'b0;
            dat_valid <= 1'b1;
            if (len != 8'd0) begin
              dat_data <= mem[rd[AW-1:0]];
              state    <= SEND_DAT;
            end else begin
              dat_data <= crc_tx;
              state    <= SEND_CRC;
            end
          end
        end

        SEND_DAT: begin
          if (dat_ready) begin
            rd <= rd + 8'd1;
            if (rd == (len - 8'd1)) begin
              dat_data <= crc_tx;
              state    <= SEND_CRC;
            end else begin
              dat_data <= mem[rd_nidx];
            end
          end
        end

        SEND_CRC: begin
          if (dat_ready) begin
            dat_valid <= 1'b0;
            res_ready <= 1'b1;
            timer     <= '0;
            state     <= WAIT_RES;
          end
        end

        WAIT_RES: begin
          timer <= timer + TW'(1);
          // A token on the expiry cycle still counts as the answer.
          if (res_valid || (timer == TMO_LAST)) begin
            pass      <= res_valid && res_data;
            ovf       <= ovf_flag;
            done      <= 1'b1;
            res_ready <= 1'b0;
            state     <= REPORT;
          end
        end

        REPORT: begin
          done     <= 1'b0;
          pass     <= 1'b0;
          ovf      <= 1'b0;
          len      <= 8'd0;
          rd       <= 8'd0;
          timer    <= '0;
          ovf_flag <= 1'b0;
          in_ready <= 1'b1;
          state    <= FILL;
        end

        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
